seq_detect_moore: RTL and testbench

- Moore finite-state machine that detects a serial bit pattern (default 1011) on a 1-bit input stream sampled once per clock.
- Output z depends only on the current state and asserts for one cycle per detected occurrence.
- Sits at the edge of serial-protocol logic as a framing/sync-word detector.
- Overlapping detection by default; non-overlapping selectable by parameter.

---
 rtl/seq_detect_moore_pkg.sv | 17 +
 rtl/seq_detect_moore_if.sv | 31 +++
 rtl/seq_detect_moore.sv | 83 ++++++++
 tb/tb_seq_detect_moore.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_moore_pkg.sv
// Shared types and constants for the seq_detect_moore serial pattern detector.
// Imported by the interface and the detector top.
package seq_detect_pkg;

  localparam int STATE_W = 3;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

endpackage

// File: rtl/seq_detect_moore_if.sv
// Serial-in / detect-out bundle for seq_detect_moore.
// match_count exists only when SEQ_DETECT_MATCH_CNT_EN is defined.
interface seq_detect_if;
  import seq_detect_pkg::*;

  logic               x;
  logic               z;
  logic [STATE_W-1:0] state;
`ifdef SEQ_DETECT_MATCH_CNT_EN
  logic [15:0]        match_count;
`endif

  modport master (
    output x,
`ifdef SEQ_DETECT_MATCH_CNT_EN
    input  match_count,
`endif
    input  z,
    input  state
  );

  modport slave (
    input  x,
`ifdef SEQ_DETECT_MATCH_CNT_EN
    output match_count,
`endif
    output z,
    output state
  );

endinterface

// File: rtl/seq_detect_moore.sv
// Moore detector for a 4-bit serial pattern, overlapping or not.
// SEQ_DETECT_MATCH_CNT_EN adds a saturating 16-bit match counter.
module seq_detect_moore
  import seq_detect_pkg::*;
#(
  parameter logic [3:0] PATTERN = DEFAULT_PATTERN,
  parameter bit         OVERLAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  seq_detect_if.slave bus
);

  state_t state_q;
  state_t state_d;

  // Longest pattern prefix that is a suffix of prefix(k) followed by b.
  function automatic logic [2:0] kmp_next(
    input logic [2:0] k,
    input logic       b
  );
    logic [7:0] h;
    logic       ok;
    logic [2:0] res;
    int         n;
    h = '0;
    n = int'(k) + 1;
    for (int j = 0; j < 4; j++)
      if (j < int'(k))
        h[3'(j)] = PATTERN[2'(3 - j)];
    h[k] = b;
    res = '0;
    for (int l = 1; l <= 4; l++) begin
      ok = (l <= n);
      for (int i = 0; i < 4; i++)
        if (i < l &&
            h[3'(n - l + i)] != PATTERN[2'(3 - i)])
          ok = 1'b0;
      if (ok)
        res = 3'(l);
    end
    return res;
  endfunction

  always_comb begin
    state_d = S0;
    unique case (1'b1)
      (state_q == S4):
        state_d = state_t'(kmp_next(
          OVERLAP ? 3'(state_q) : 3'd0, bus.x));
      (state_q inside {S0, S1, S2, S3}):
        state_d = state_t'(kmp_next(
          3'(state_q), bus.x));
      default:
        state_d = S0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= S0;
    else
      state_q <= state_d;
  end

  assign bus.z     = (state_q == S4);
  assign bus.state = state_q;

`ifdef SEQ_DETECT_MATCH_CNT_EN
  logic [15:0] match_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      match_cnt_q <= '0;
    else if (state_d == S4 &&
             match_cnt_q != 16'hFFFF)
      match_cnt_q <= match_cnt_q + 16'd1;
  end

  assign bus.match_count = match_cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_moore.sv
// Self-checking bench: overlapping and non-overlapping detectors side by side.
// Counter checks are active when SEQ_DETECT_MATCH_CNT_EN is defined.
module tb_seq_detect_moore;
  import seq_detect_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic xb = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   p_ov = 0;
  int   p_no = 0;

  always #5 clk = ~clk;

  seq_detect_if ov_if ();
  seq_detect_if no_if ();

  assign ov_if.x = xb;
  assign no_if.x = xb;

  seq_detect_moore #(
    .PATTERN (4'b1011),
    .OVERLAP (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ov_if)
  );

  seq_detect_moore #(
    .PATTERN (4'b1011),
    .OVERLAP (1'b0)
  ) dut_no (
    .clk   (clk),
    .reset (reset),
    .bus   (no_if)
  );

  typedef struct {
    logic [2:0]  s_ov;
    logic [2:0]  s_no;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  logic [2:0]  m_ov = 3'd0;
  logic [2:0]  m_no = 3'd0;
  logic [15:0] m_cnt = 16'd0;

  // Transition table for 1011 written out state by state.
  function automatic logic [2:0] ref_next(
    input logic [2:0] s,
    input logic       b,
    input bit         ov
  );
    case (s)
      3'd0: return b ? 3'd1 : 3'd0;
      3'd1: return b ? 3'd1 : 3'd2;
      3'd2: return b ? 3'd3 : 3'd0;
      3'd3: return b ? 3'd4 : 3'd2;
      3'd4: return b ? 3'd1 : (ov ? 3'd2 : 3'd0);
      default: return 3'd0;
    endcase
  endfunction

  task automatic step(input logic b);
    exp_t e;
    @(negedge clk);
    xb = b;
    m_ov = ref_next(m_ov, b, 1'b1);
    m_no = ref_next(m_no, b, 1'b0);
    if (m_ov == 3'd4 && m_cnt != 16'hFFFF)
      m_cnt = m_cnt + 16'd1;
    e.s_ov = m_ov;
    e.s_no = m_no;
    e.cnt  = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #2;
    if (ov_if.z) p_ov++;
    if (no_if.z) p_no++;
  endtask

  task automatic drive(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--)
      step(bits[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #3;
    m_ov  = 3'd0;
    m_no  = 3'd0;
    m_cnt = 16'd0;
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    p_ov = 0;
    p_no = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      me = sb.pop_front();
      checks++;
      if (ov_if.state !== me.s_ov ||
          ov_if.z !== (me.s_ov == 3'd4)) begin
        errors++;
        $display("FAIL sb_ov state=%0d z=%b want state=%0d",
                 ov_if.state, ov_if.z, me.s_ov);
      end
      checks++;
      if (no_if.state !== me.s_no ||
          no_if.z !== (me.s_no == 3'd4)) begin
        errors++;
        $display("FAIL sb_no state=%0d z=%b want state=%0d",
                 no_if.state, no_if.z, me.s_no);
      end
`ifdef SEQ_DETECT_MATCH_CNT_EN
      checks++;
      if (ov_if.match_count !== me.cnt) begin
        errors++;
        $display("FAIL sb_cnt got=%h want=%h",
                 ov_if.match_count, me.cnt);
      end
`endif
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    xb = 1'b0;
    #1;
    reset = 1'b0;
    #10;
    checks++;
    if (ov_if.state !== 3'd0 || ov_if.z !== 1'b0 ||
        no_if.state !== 3'd0 || no_if.z !== 1'b0) begin
      errors++;
      $display("FAIL reset state=%0d/%0d z=%b/%b want 0",
               ov_if.state, no_if.state, ov_if.z, no_if.z);
    end
`ifdef SEQ_DETECT_MATCH_CNT_EN
    checks++;
    if (ov_if.match_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%h want=0",
               ov_if.match_count);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    drive(16'b1011, 4);
    checks++;
    if (ov_if.z !== 1'b1 || p_ov != 1) begin
      errors++;
      $display("FAIL basic_hit z=%b pulses=%0d want 1/1",
               ov_if.z, p_ov);
    end
    step(1'b0);
    checks++;
    if (ov_if.z !== 1'b0 || p_ov != 1) begin
      errors++;
      $display("FAIL basic_drop z=%b pulses=%0d want 0/1",
               ov_if.z, p_ov);
    end
  endtask

  task automatic test_overlap();
    do_reset();
    drive(16'b1011011, 7);
    checks++;
    if (p_ov != 2 || p_no != 1) begin
      errors++;
      $display("FAIL overlap pulses=%0d/%0d want 2/1",
               p_ov, p_no);
    end
  endtask

  task automatic test_near_miss();
    do_reset();
    drive(16'b1101011, 7);
    checks++;
    if (p_ov != 1 || ov_if.z !== 1'b1) begin
      errors++;
      $display("FAIL near1 pulses=%0d z=%b want 1/1",
               p_ov, ov_if.z);
    end
    do_reset();
    drive(16'b10011, 5);
    checks++;
    if (p_ov != 0 || p_no != 0) begin
      errors++;
      $display("FAIL near2 pulses=%0d/%0d want 0/0",
               p_ov, p_no);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(16'b101, 3);
    checks++;
    if (ov_if.state !== 3'd3) begin
      errors++;
      $display("FAIL pre_mid state=%0d want 3",
               ov_if.state);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (ov_if.state !== 3'd0 || no_if.state !== 3'd0 ||
        ov_if.z !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset state=%0d/%0d want 0",
               ov_if.state, no_if.state);
    end
    m_ov  = 3'd0;
    m_no  = 3'd0;
    m_cnt = 16'd0;
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    step(1'b1);
    checks++;
    if (ov_if.state !== 3'd1) begin
      errors++;
      $display("FAIL post_mid state=%0d want 1",
               ov_if.state);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(16'b101110111011, 12);
    checks++;
    if (p_ov != 3 || p_no != 3) begin
      errors++;
      $display("FAIL b2b pulses=%0d/%0d want 3/3",
               p_ov, p_no);
    end
`ifdef SEQ_DETECT_MATCH_CNT_EN
    checks++;
    if (ov_if.match_count !== 16'd3) begin
      errors++;
      $display("FAIL cnt3 got=%h want=0003",
               ov_if.match_count);
    end
    @(negedge clk);
    force dut.match_cnt_q = 16'hFFFE;
    #1;
    release dut.match_cnt_q;
    m_cnt = 16'hFFFE;
    drive(16'b1011011, 7);
    checks++;
    if (ov_if.match_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_sat got=%h want=ffff",
               ov_if.match_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_near_miss();
    test_mid_reset();
    test_back_to_back();
    repeat (2) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
